// File: rtl/tmds_decoder_pkg.sv
// Shared TMDS constants: DVI control tokens, alignment FSM states and the
// bit-slip wrap helper used by the decoder and its symbol decoder.
package tmds_decoder_pkg;

  localparam logic [9:0] CTL_TOK_00 = 10'b1101010100;
  localparam logic [9:0] CTL_TOK_01 = 10'b0010101011;
  localparam logic [9:0] CTL_TOK_10 = 10'b0101010100;
  localparam logic [9:0] CTL_TOK_11 = 10'b1010101011;

  localparam logic [3:0] OFFSET_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  // Bit-slip offsets cycle 0..9 and wrap back to 0.
  function automatic logic [3:0] next_offset(input logic [3:0] cur);
    return (cur >= OFFSET_MAX) ? 4'd0 : cur + 4'd1;
  endfunction

endpackage

// File: rtl/tmds_decoder_symbol_decode.sv
// Combinational TMDS symbol decoder: recovers the pixel byte from a 10-bit
// symbol and flags the four DVI control tokens with their {c1,c0} value.
module tmds_decoder_symbol_decode
  import tmds_decoder_pkg::*;
(
  input  logic [9:0] q_i,
  output logic [7:0] data_o,
  output logic       is_tok_o,
  output logic [1:0] tok_ctl_o
);

  logic [7:0] d_s;

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  always_comb begin
    d_s       = q_i[9] ? ~q_i[7:0] : q_i[7:0];
    data_o    = 8'd0;
    data_o[0] = d_s[0];
    for (int i = 1; i < 8; i++) begin
      data_o[i] = q_i[8] ? (d_s[i] ^ d_s[i-1]) : ~(d_s[i] ^ d_s[i-1]);
    end
  end

  // Control token recognition.
  always_comb begin
    is_tok_o  = 1'b0;
    tok_ctl_o = 2'b00;
    case (q_i)
      CTL_TOK_00: begin is_tok_o = 1'b1; tok_ctl_o = 2'b00; end
      CTL_TOK_01: begin is_tok_o = 1'b1; tok_ctl_o = 2'b01; end
      CTL_TOK_10: begin is_tok_o = 1'b1; tok_ctl_o = 2'b10; end
      CTL_TOK_11: begin is_tok_o = 1'b1; tok_ctl_o = 2'b11; end
      default:    begin is_tok_o = 1'b0; tok_ctl_o = 2'b00; end
    endcase
  end

endmodule

// File: rtl/tmds_decoder.sv
// Single-channel TMDS receiver: hunts word alignment over a 20-bit window
// using control tokens, then decodes pixel data, control bits and DE.
module tmds_decoder
  import tmds_decoder_pkg::*;
#(
  parameter int LOCK_COUNT   = 8,
  parameter int SEARCH_DWELL = 4096
) (
  input  logic       clk_dot4x,
  input  logic       rst,
  input  logic [9:0] tmds_word,
  output logic [7:0] data,
  output logic [1:0] ctl,
  output logic       de,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int IDLE_W = (SEARCH_DWELL > 2) ? $clog2(SEARCH_DWELL) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(SEARCH_DWELL - 1);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_ZERO = {IDLE_W{1'b0}};
  localparam logic [3:0]        LOCK_LAST = 4'(LOCK_COUNT);

  state_e            state_q, state_d;
  logic [9:0]        prev_word_q;
  logic [9:0]        sym_q;
  logic [3:0]        tok_cnt_q, tok_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [3:0]        offset_q, offset_d;
  logic [7:0]        data_q, data_d;
  logic [1:0]        ctl_q, ctl_d;
  logic              de_q, de_d;
  logic              locked_q, locked_d;

  logic [19:0]       window_s;
  logic [9:0]        sym_s;
  logic [7:0]        dec_data_s;
  logic              is_tok_s;
  logic [1:0]        tok_ctl_s;

  // Newest word sits above the previous one, so bit 0 is the oldest wire bit.
  assign window_s = {tmds_word, prev_word_q};
  assign sym_s    = 10'(window_s >> offset_q);

  tmds_decoder_symbol_decode u_sym_dec (
    .q_i       (sym_q),
    .data_o    (dec_data_s),
    .is_tok_o  (is_tok_s),
    .tok_ctl_o (tok_ctl_s)
  );

  // Alignment FSM next state and decoded output next values.
  always_comb begin
    state_d    = state_q;
    tok_cnt_d  = tok_cnt_q;
    idle_cnt_d = idle_cnt_q;
    offset_d   = offset_q;
    data_d     = data_q;
    ctl_d      = ctl_q;
    de_d       = 1'b0;
    locked_d   = locked_q;
    case (state_q)
      ST_SEARCH: begin
        if (is_tok_s) begin
          state_d    = ST_CONFIRM;
          tok_cnt_d  = 4'd1;
          idle_cnt_d = IDLE_ZERO;
        end else if (idle_cnt_q == IDLE_LAST) begin
          offset_d   = next_offset(offset_q);
          idle_cnt_d = IDLE_ZERO;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_ONE;
        end
      end
      ST_CONFIRM: begin
        if (is_tok_s) begin
          tok_cnt_d = tok_cnt_q + 4'd1;
          if (tok_cnt_d == LOCK_LAST) begin
            state_d    = ST_LOCKED;
            locked_d   = 1'b1;
            ctl_d      = tok_ctl_s;
            idle_cnt_d = IDLE_ZERO;
          end else begin
            state_d = ST_CONFIRM;
          end
        end else begin
          // A broken run means this offset was a false hit.
          offset_d   = next_offset(offset_q);
          state_d    = ST_SEARCH;
          tok_cnt_d  = 4'd0;
          idle_cnt_d = IDLE_ZERO;
        end
      end
      ST_LOCKED: begin
        if (is_tok_s) begin
          idle_cnt_d = IDLE_ZERO;
          ctl_d      = tok_ctl_s;
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d    = ST_SEARCH;
          locked_d   = 1'b0;
          data_d     = 8'd0;
          ctl_d      = 2'b00;
          tok_cnt_d  = 4'd0;
          idle_cnt_d = IDLE_ZERO;
        end else begin
          data_d     = dec_data_s;
          de_d       = 1'b1;
          idle_cnt_d = idle_cnt_q + IDLE_ONE;
        end
      end
      default: begin
        state_d    = ST_SEARCH;
        tok_cnt_d  = 4'd0;
        idle_cnt_d = IDLE_ZERO;
        offset_d   = 4'd0;
        data_d     = 8'd0;
        ctl_d      = 2'b00;
        locked_d   = 1'b0;
      end
    endcase
  end

  // Window, symbol pipeline, FSM and output registers.
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      prev_word_q <= 10'd0;
      sym_q       <= 10'd0;
      state_q     <= ST_SEARCH;
      tok_cnt_q   <= 4'd0;
      idle_cnt_q  <= IDLE_ZERO;
      offset_q    <= 4'd0;
      data_q      <= 8'd0;
      ctl_q       <= 2'b00;
      de_q        <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      prev_word_q <= tmds_word;
      sym_q       <= sym_s;
      state_q     <= state_d;
      tok_cnt_q   <= tok_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      offset_q    <= offset_d;
      data_q      <= data_d;
      ctl_q       <= ctl_d;
      de_q        <= de_d;
      locked_q    <= locked_d;
    end
  end

  assign data   = data_q;
  assign ctl    = ctl_q;
  assign de     = de_q;
  assign locked = locked_q;
  assign offset = offset_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// Bench for tmds_decoder: a bit-stream generator with arbitrary skew feeds the
// DUT, and a cycle reference model plus an encode/decode round trip check it.
module tb_tmds_decoder;

  localparam int LOCK_N = 8;
  localparam int DWELL  = 16;
  localparam int HUNT = 0, CONF = 1, LOCK = 2;

  logic       clk_dot4x = 1'b0;
  logic       rst       = 1'b1;
  logic [9:0] tmds_word = 10'd0;
  logic [7:0] data;
  logic [1:0] ctl;
  logic       de;
  logic       locked;
  logic [3:0] offset;

  tmds_decoder #(.LOCK_COUNT(LOCK_N), .SEARCH_DWELL(DWELL)) dut (
    .clk_dot4x (clk_dot4x),
    .rst       (rst),
    .tmds_word (tmds_word),
    .data      (data),
    .ctl       (ctl),
    .de        (de),
    .locked    (locked),
    .offset    (offset)
  );

  always #5 clk_dot4x = ~clk_dot4x;

  int ntests = 0;
  int nfail  = 0;

  bit         bitq[$];
  logic [7:0] exp_q[$];
  logic [3:0] walk_q[$];
  bit         track   = 1'b0;
  bit         walk_on = 1'b0;
  int         de_seen = 0;

  logic [9:0] tok_tab [4] = '{10'b1101010100, 10'b0010101011,
                              10'b0101010100, 10'b1010101011};

  // Reference model state (plain integers and counters of quiet cycles).
  int         m_mode, m_run, m_quiet, m_off;
  logic [9:0] m_prev, m_pend;
  logic [7:0] m_data;
  logic [1:0] m_ctl;
  logic       m_de, m_locked;

  function automatic int tok_index(input logic [9:0] q);
    for (int c = 0; c < 4; c++) if (q == tok_tab[c]) return c;
    return -1;
  endfunction

  function automatic logic [7:0] ref_data(input logic [9:0] q);
    logic [7:0] d, o;
    d = q[9] ? ~q[7:0] : q[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  // DVI transition-minimising encode; q[9] (inversion) chosen by caller.
  function automatic logic [9:0] encode(input logic [7:0] b, input bit inv);
    logic [7:0] qm;
    bit use_xnor;
    use_xnor = ($countones(b) > 4) || (($countones(b) == 4) && (b[0] == 1'b0));
    qm[0] = b[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ b[i]) : (qm[i-1] ^ b[i]);
    return {inv, ~use_xnor, inv ? ~qm : qm};
  endfunction

  function automatic void model_step(input logic [9:0] w, input logic r);
    logic [9:0]  s;
    logic [19:0] win;
    int c;
    if (r) begin
      m_mode = HUNT; m_run = 0; m_quiet = 0; m_off = 0;
      m_prev = 10'd0; m_pend = 10'd0; m_data = 8'd0; m_ctl = 2'd0;
      m_de = 1'b0; m_locked = 1'b0;
      return;
    end
    s      = m_pend;
    win    = {w, m_prev};
    m_pend = win[m_off +: 10];
    m_prev = w;
    c      = tok_index(s);
    m_de   = 1'b0;
    case (m_mode)
      HUNT: begin
        if (c >= 0) begin m_mode = CONF; m_run = 1; m_quiet = 0; end
        else begin
          m_quiet++;
          if (m_quiet == DWELL) begin m_off = (m_off + 1) % 10; m_quiet = 0; end
        end
      end
      CONF: begin
        if (c >= 0) begin
          m_run++;
          if (m_run == LOCK_N) begin
            m_mode = LOCK; m_locked = 1'b1; m_ctl = 2'(c); m_quiet = 0;
          end
        end else begin
          m_off = (m_off + 1) % 10; m_mode = HUNT; m_quiet = 0;
        end
      end
      LOCK: begin
        if (c >= 0) begin m_quiet = 0; m_ctl = 2'(c); end
        else begin
          m_quiet++;
          if (m_quiet == DWELL) begin
            m_mode = HUNT; m_locked = 1'b0; m_data = 8'd0; m_ctl = 2'd0; m_quiet = 0;
          end else begin
            m_data = ref_data(s); m_de = 1'b1;
          end
        end
      end
      default: ;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ntests++;
    assert (obs === expv)
      else begin
        nfail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
  endtask

  task automatic tick();
    @(posedge clk_dot4x);
    #1;
    model_step(tmds_word, rst);
    check("data",   data,   m_data);
    check("ctl",    ctl,    m_ctl);
    check("de",     de,     m_de);
    check("locked", locked, m_locked);
    check("offset", offset, m_off);
    if (de === 1'b1) de_seen++;
    if (track && de === 1'b1) begin
      if (exp_q.size() > 0) check("roundtrip", data, exp_q.pop_front());
      else check("spurious_de", de, 1'b0);
    end
    if (walk_on && offset !== walk_q[$]) walk_q.push_back(offset);
  endtask

  task automatic push_sym(input logic [9:0] q);
    for (int i = 0; i < 10; i++) bitq.push_back(q[i]);
  endtask

  task automatic push_tok(input int c);
    push_sym(tok_tab[c]);
  endtask

  task automatic push_data(input logic [7:0] b, input bit inv, input bit keep);
    push_sym(encode(b, inv));
    if (keep) exp_q.push_back(b);
  endtask

  task automatic run_words(input int n);
    logic [9:0] w;
    for (int k = 0; k < n; k++) begin
      w = 10'd0;
      for (int i = 0; i < 10; i++) if (bitq.size() > 0) w[i] = bitq.pop_front();
      tmds_word = w;
      tick();
    end
  endtask

  // Reset for two edges, then start a fresh stream skewed by pre junk bits.
  task automatic do_reset(input int pre);
    rst = 1'b1;
    tmds_word = 10'd0;
    tick();
    tick();
    rst = 1'b0;
    bitq.delete();
    exp_q.delete();
    for (int i = 0; i < pre; i++) bitq.push_back(1'b0);
  endtask

  initial begin
    int first_lock;
    logic [15:0] walk;

    // Aligned token stream locks quickly at offset 0.
    do_reset(0);
    for (int i = 0; i < 20; i++) push_tok(0);
    first_lock = 0;
    for (int i = 0; i < 20; i++) begin
      run_words(1);
      if (first_lock == 0 && locked === 1'b1) first_lock = i + 1;
    end
    check("lock_within_10", (first_lock >= 1 && first_lock <= 10), 1'b1);
    check("p1_ctl", ctl, 2'b00);
    check("p1_offset", offset, 4'd0);

    // Stream skewed by 3 bits: offset walks 0,1,2,3 then locks.
    do_reset(3);
    walk_q.delete();
    walk_q.push_back(4'd0);
    walk_on = 1'b1;
    for (int i = 0; i < 70; i++) push_tok(0);
    run_words(65);
    walk_on = 1'b0;
    walk = 16'd0;
    for (int i = 0; i < 4; i++) walk = (walk << 4) | ((i < walk_q.size()) ? 16'(walk_q[i]) : 16'hF);
    check("offset_walk", walk, 16'h0123);
    check("offset_walk_len", walk_q.size(), 4);
    check("p2_locked", locked, 1'b1);
    check("p2_offset", offset, 4'd3);

    // Locked data: fixed corner bytes then random data/token bursts.
    track = 1'b1;
    push_data(8'h00, 1'($urandom_range(0, 1)), 1'b1);
    push_data(8'hFF, 1'($urandom_range(0, 1)), 1'b1);
    push_data(8'hA5, 1'($urandom_range(0, 1)), 1'b1);
    push_data(8'h3C, 1'($urandom_range(0, 1)), 1'b1);
    push_tok(0);
    for (int r = 0; r < 8; r++) begin
      int n;
      n = int'($urandom_range(1, 4));
      for (int k = 0; k < n; k++) push_data(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1);
      push_tok(int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 6; i++) push_tok(0);
    while (bitq.size() >= 10) run_words(1);
    check("roundtrip_drain", exp_q.size(), 0);
    check("p3_locked", locked, 1'b1);
    check("p3_offset", offset, 4'd3);
    track = 1'b0;

    // Short token run broken by data: offset advances, no lock.
    do_reset(0);
    for (int i = 0; i < 5; i++) push_tok(0);
    for (int i = 0; i < 4; i++) push_data(8'h00, 1'b0, 1'b0);
    run_words(12);
    check("p4_offset", offset, 4'd1);
    check("p4_locked", locked, 1'b0);

    // Data-only after lock: lock drops at dwell expiry, offset kept.
    do_reset(0);
    for (int i = 0; i < 12; i++) push_tok(0);
    for (int i = 0; i < 24; i++) push_data(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
    de_seen = 0;
    run_words(40);
    check("dwell_de_count", de_seen, DWELL - 1);
    check("p5_locked", locked, 1'b0);
    check("p5_offset", offset, 4'd0);
    check("p5_de", de, 1'b0);

    // Reset mid-CONFIRM: relock needs a full run afterwards.
    do_reset(0);
    for (int i = 0; i < 4; i++) push_tok(0);
    run_words(5);
    do_reset(0);
    check("rst_confirm", {data, ctl, de, locked, offset}, 16'd0);
    for (int i = 0; i < 12; i++) push_tok(0);
    run_words(9);
    check("relock_not_early", locked, 1'b0);
    run_words(1);
    check("relock_full_run", locked, 1'b1);

    // Reset mid-LOCKED at a non-zero offset.
    do_reset(3);
    for (int i = 0; i < 80; i++) push_tok(1);
    run_words(75);
    check("p6_locked", locked, 1'b1);
    check("p6_ctl", ctl, 2'b01);
    do_reset(0);
    check("rst_locked", {data, ctl, de, locked, offset}, 16'd0);
    run_words(3);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
